// File: rtl/tdc_meas_ctrl.sv
// ---------------------------------------------------------------------------
// tdc_meas_ctrl
//
// Measurement sequencer wrapped around a ring-oscillator TDC stage. For each
// accepted trigger it runs a burst of 2^LOG2_AVG gated measurements. Each
// measurement is a one-cycle start pulse, a W-cycle gate, a two-cycle stop
// pulse and a one-cycle capture of time_count. The burst mean, minimum,
// maximum and an all-ones overflow flag are then offered through a
// valid/ready handshake.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active HIGH (historical name kept)
//   trig          request a burst (honoured only in IDLE with no pending result)
//   window        gate length in cycles, sampled on trigger acceptance (0 -> 1)
//   time_count    count delivered by the TDC stage
//   tdc_start     registered TDC start pulse
//   tdc_stop      registered TDC stop pulse (two cycles)
//   busy          high whenever the sequencer is not in IDLE
//   result        burst mean, accumulator >> LOG2_AVG (truncating)
//   result_min    smallest sample of the burst
//   result_max    largest sample of the burst
//   overflow      at least one sample of the burst was all-ones
//   result_valid  result outputs are stable while high
//   result_ready  consumer accepts the result
// ---------------------------------------------------------------------------
module tdc_meas_ctrl #(
   parameter int CNT_W    = 32,
   parameter int WIN_W    = 16,
   parameter int LOG2_AVG = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [WIN_W-1:0] window,
   input  logic [CNT_W-1:0] time_count,
   output logic             tdc_start,
   output logic             tdc_stop,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic [CNT_W-1:0] result_min,
   output logic [CNT_W-1:0] result_max,
   output logic             overflow,
   output logic             result_valid,
   input  logic             result_ready
);

   // The accumulator carries LOG2_AVG extra bits so a full burst of
   // all-ones samples cannot wrap.
   localparam int ACC_W = CNT_W + LOG2_AVG;
   // Keep the sample index at least one bit wide for single-sample bursts.
   localparam int IDX_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << LOG2_AVG) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_STOP,
      S_CAPT,
      S_DONE
   } state_t;

   state_t           state_q,   state_d;
   logic [WIN_W-1:0] win_q,     win_d;
   logic [WIN_W-1:0] cnt_q,     cnt_d;
   logic             stop2_q,   stop2_d;     // second cycle of the stop pulse
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [ACC_W-1:0] acc_q,     acc_d;
   logic [CNT_W-1:0] run_min_q, run_min_d;
   logic [CNT_W-1:0] run_max_q, run_max_d;
   logic             run_ovf_q, run_ovf_d;
   logic [CNT_W-1:0] res_q,     res_d;
   logic [CNT_W-1:0] res_min_q, res_min_d;
   logic [CNT_W-1:0] res_max_q, res_max_d;
   logic             res_ovf_q, res_ovf_d;
   logic             start_q,   start_d;
   logic             stop_q,    stop_d;
   logic             valid_q,   valid_d;

   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] min_nx;
   logic [CNT_W-1:0] max_nx;
   logic             ovf_nx;

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skips an assignment would otherwise infer a latch.
      state_d   = state_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      stop2_d   = stop2_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      run_min_d = run_min_q;
      run_max_d = run_max_q;
      run_ovf_d = run_ovf_q;
      res_d     = res_q;
      res_min_d = res_min_q;
      res_max_d = res_max_q;
      res_ovf_d = res_ovf_q;

      // Running statistics including the sample presented this cycle.
      acc_sum = acc_q + ACC_W'(time_count);
      min_nx  = (time_count < run_min_q) ? time_count : run_min_q;
      max_nx  = (time_count > run_max_q) ? time_count : run_max_q;
      ovf_nx  = run_ovf_q | (time_count == '1);

      unique case (state_q)
         S_IDLE: begin
            if (trig && !valid_q) begin
               win_d     = (window == '0) ? WIN_W'(1) : window;
               acc_d     = '0;
               idx_d     = '0;
               run_ovf_d = 1'b0;
               run_min_d = '1;
               run_max_d = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            cnt_d   = win_q - WIN_W'(1);
            state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               stop2_d = 1'b0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q - WIN_W'(1);
            end
         end
         S_STOP: begin
            // First cycle clears the TDC counting flag, second loads its count.
            if (stop2_q) begin
               stop2_d = 1'b0;
               state_d = S_CAPT;
            end else begin
               stop2_d = 1'b1;
            end
         end
         S_CAPT: begin
            acc_d     = acc_sum;
            run_min_d = min_nx;
            run_max_d = max_nx;
            run_ovf_d = ovf_nx;
            if (idx_q == IDX_LAST) begin
               // Published outputs change only here, so a burst aborted by
               // reset never exposes partial statistics.
               res_d     = CNT_W'(acc_sum >> LOG2_AVG);
               res_min_d = min_nx;
               res_max_d = max_nx;
               res_ovf_d = ovf_nx;
               state_d   = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_START;
            end
         end
         S_DONE: begin
            if (valid_q && result_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pin registers follow the next state so each pin is high exactly
      // while the sequencer sits in the matching state.
      start_d = (state_d == S_START);
      stop_d  = (state_d == S_STOP);
      valid_d = (state_d == S_DONE);
   end

   // NOTE: the reset is active HIGH despite its name; the sensitivity and
   // the test both use the asserted-high level.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q   <= S_IDLE;
         win_q     <= '0;
         cnt_q     <= '0;
         stop2_q   <= 1'b0;
         idx_q     <= '0;
         acc_q     <= '0;
         run_min_q <= '0;
         run_max_q <= '0;
         run_ovf_q <= 1'b0;
         res_q     <= '0;
         res_min_q <= '0;
         res_max_q <= '0;
         res_ovf_q <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q   <= state_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         stop2_q   <= stop2_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         run_min_q <= run_min_d;
         run_max_q <= run_max_d;
         run_ovf_q <= run_ovf_d;
         res_q     <= res_d;
         res_min_q <= res_min_d;
         res_max_q <= res_max_d;
         res_ovf_q <= res_ovf_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         valid_q   <= valid_d;
      end
   end

   assign tdc_start    = start_q;
   assign tdc_stop     = stop_q;
   assign busy         = (state_q != S_IDLE);
   assign result       = res_q;
   assign result_min   = res_min_q;
   assign result_max   = res_max_q;
   assign overflow     = res_ovf_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
module tb_tdc_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;

   // Main instance: LOG2_AVG = 2 (4 samples per burst)
   logic        trig, tdc_start, tdc_stop, busy, overflow, valid, ready;
   logic [15:0] window;
   logic [31:0] tc, res, rmin, rmax;

   // Second instance: LOG2_AVG = 0 (1 sample per burst)
   logic        trig0, tdc_start0, tdc_stop0, busy0, overflow0, valid0, ready0;
   logic [15:0] window0;
   logic [31:0] tc0, res0, rmin0, rmax0;

   int n_checks = 0;
   int n_fail   = 0;
   int excl_viol = 0;

   // TDC models: a new sample appears on time_count in each start cycle.
   logic [31:0] samp [8];
   int          sidx;
   logic [31:0] samp0 [2];
   int          sidx0;

   always #5 clk = ~clk;

   tdc_meas_ctrl #(.CNT_W(32), .WIN_W(16), .LOG2_AVG(2)) dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .window(window), .time_count(tc),
      .tdc_start(tdc_start), .tdc_stop(tdc_stop), .busy(busy), .result(res),
      .result_min(rmin), .result_max(rmax), .overflow(overflow),
      .result_valid(valid), .result_ready(ready)
   );

   tdc_meas_ctrl #(.CNT_W(32), .WIN_W(16), .LOG2_AVG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .trig(trig0), .window(window0), .time_count(tc0),
      .tdc_start(tdc_start0), .tdc_stop(tdc_stop0), .busy(busy0), .result(res0),
      .result_min(rmin0), .result_max(rmax0), .overflow(overflow0),
      .result_valid(valid0), .result_ready(ready0)
   );

   always @(negedge clk) begin
      if (tdc_start) begin
         tc = samp[sidx[2:0]];
         sidx++;
      end
      if (tdc_start0) begin
         tc0 = samp0[sidx0[0]];
         sidx0++;
      end
      if ((tdc_start && tdc_stop) || (tdc_start0 && tdc_stop0)) excl_viol++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Pulse trig and follow the burst; returns at the negedge where
   // result_valid is first seen high. Cycle 0 is the first tdc_start cycle.
   task automatic run_burst(input logic [15:0] w, output int t_stop, output int t_valid);
      sidx = 0;
      @(negedge clk) trig = 1'b1; window = w;
      @(negedge clk) trig = 1'b0;
      t_stop  = -1;
      t_valid = -1;
      n_checks++;
      if (tdc_start !== 1'b1) begin
         $display("FAIL start_latency: tdc_start=%b expected 1", tdc_start); n_fail++;
      end
      for (int c = 0; c < 600; c++) begin
         if (tdc_stop && t_stop < 0) t_stop = c;
         if (valid) begin t_valid = c; break; end
         @(negedge clk);
      end
   endtask

   task automatic xfer(input logic [31:0] exp_res);
      @(negedge clk) ready = 1'b1;
      @(negedge clk) ready = 1'b0;
      n_checks++;
      if ({valid, busy} !== 2'b00) begin
         $display("FAIL xfer_idle: valid,busy=%b expected 00", {valid, busy}); n_fail++;
      end
      n_checks++;
      if (res !== exp_res) begin
         $display("FAIL xfer_hold: result=%0h expected %0h", res, exp_res); n_fail++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({tdc_start, tdc_stop, busy, valid, overflow} !== 5'b0) begin
         $display("FAIL reset_ctrl: start,stop,busy,valid,ovf=%b expected 00000",
                  {tdc_start, tdc_stop, busy, valid, overflow}); n_fail++;
      end
      n_checks++;
      if ({res, rmin, rmax} !== 96'h0) begin
         $display("FAIL reset_data: res=%0h min=%0h max=%0h expected 0 0 0", res, rmin, rmax); n_fail++;
      end
      rst_n = 1'b0;
   endtask

   task automatic test_basic;
      int ts, tv;
      samp[0] = 100; samp[1] = 102; samp[2] = 104; samp[3] = 106;
      run_burst(16'd10, ts, tv);
      n_checks++; if (tv !== 56) begin $display("FAIL basic_valid_time: got %0d expected 56", tv); n_fail++; end
      n_checks++; if (ts !== 11) begin $display("FAIL basic_stop_time: got %0d expected 11", ts); n_fail++; end
      n_checks++; if (res !== 32'd103) begin $display("FAIL basic_mean: got %0d expected 103", res); n_fail++; end
      n_checks++; if (rmin !== 32'd100) begin $display("FAIL basic_min: got %0d expected 100", rmin); n_fail++; end
      n_checks++; if (rmax !== 32'd106) begin $display("FAIL basic_max: got %0d expected 106", rmax); n_fail++; end
      n_checks++; if (overflow !== 1'b0) begin $display("FAIL basic_ovf: got %b expected 0", overflow); n_fail++; end
      n_checks++; if (busy !== 1'b1) begin $display("FAIL basic_busy: got %b expected 1", busy); n_fail++; end
      xfer(32'd103);
   endtask

   task automatic test_window_zero;
      int ts, tv;
      samp[0] = 5; samp[1] = 6; samp[2] = 7; samp[3] = 8;
      run_burst(16'd0, ts, tv);
      n_checks++; if (ts !== 2) begin $display("FAIL win0_stop_time: got %0d expected 2", ts); n_fail++; end
      n_checks++; if (tv !== 20) begin $display("FAIL win0_valid_time: got %0d expected 20", tv); n_fail++; end
      n_checks++; if (res !== 32'd6) begin $display("FAIL win0_mean: got %0d expected 6", res); n_fail++; end
      xfer(32'd6);
   endtask

   task automatic test_overflow;
      int ts, tv;
      samp[0] = 32'hFFFF_FFFF; samp[1] = 1; samp[2] = 1; samp[3] = 1;
      run_burst(16'd3, ts, tv);
      n_checks++; if (tv !== 28) begin $display("FAIL ovf_valid_time: got %0d expected 28", tv); n_fail++; end
      n_checks++; if (res !== 32'h4000_0000) begin $display("FAIL ovf_mean: got %0h expected 40000000", res); n_fail++; end
      n_checks++; if (rmin !== 32'd1) begin $display("FAIL ovf_min: got %0h expected 1", rmin); n_fail++; end
      n_checks++; if (rmax !== 32'hFFFF_FFFF) begin $display("FAIL ovf_max: got %0h expected ffffffff", rmax); n_fail++; end
      n_checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_flag: got %b expected 1", overflow); n_fail++; end
   endtask

   // Continues from the pending overflow result.
   task automatic test_hold;
      int bad = 0;
      int extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         trig = (i == 5 || i == 6);
         if (tdc_start || !valid || !busy || res !== 32'h4000_0000 ||
             rmax !== 32'hFFFF_FFFF || rmin !== 32'd1 || !overflow) bad++;
      end
      trig = 1'b0;
      n_checks++; if (bad !== 0) begin $display("FAIL hold_stable: %0d bad cycles expected 0", bad); n_fail++; end
      xfer(32'h4000_0000);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (tdc_start || busy) extra++;
      end
      n_checks++; if (extra !== 0) begin $display("FAIL hold_trig_ignored: %0d active cycles expected 0", extra); n_fail++; end
   endtask

   task automatic test_reset_mid;
      int ts, tv;
      samp[0] = 50; samp[1] = 60; samp[2] = 70; samp[3] = 80;
      sidx = 0;
      @(negedge clk) trig = 1'b1; window = 16'd6;
      @(negedge clk) trig = 1'b0;
      repeat (22) @(negedge clk);   // cycle 22: RUN of the third sample
      n_checks++; if (busy !== 1'b1) begin $display("FAIL rstmid_busy_before: got %b expected 1", busy); n_fail++; end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({tdc_start, tdc_stop, busy, valid} !== 4'b0) begin
         $display("FAIL rstmid_drop: start,stop,busy,valid=%b expected 0000",
                  {tdc_start, tdc_stop, busy, valid}); n_fail++;
      end
      @(negedge clk) rst_n = 1'b0;
      samp[0] = 20; samp[1] = 30; samp[2] = 40; samp[3] = 10;
      run_burst(16'd6, ts, tv);
      n_checks++; if (tv !== 40) begin $display("FAIL rstmid_valid_time: got %0d expected 40", tv); n_fail++; end
      n_checks++; if (res !== 32'd25) begin $display("FAIL rstmid_mean: got %0d expected 25", res); n_fail++; end
      n_checks++; if (rmin !== 32'd10) begin $display("FAIL rstmid_min: got %0d expected 10", rmin); n_fail++; end
      n_checks++; if (rmax !== 32'd40) begin $display("FAIL rstmid_max: got %0d expected 40", rmax); n_fail++; end
      xfer(32'd25);
   endtask

   task automatic test_back_to_back;
      int tv1 = -1, tv2 = -1, ts5 = -1, nstart = 0, nvalid = 0;
      samp[0] = 1; samp[1] = 2; samp[2] = 3; samp[3] = 4;
      samp[4] = 8; samp[5] = 8; samp[6] = 8; samp[7] = 9;
      sidx  = 0;
      ready = 1'b1;
      @(negedge clk) trig = 1'b1; window = 16'd1;
      @(negedge clk);
      for (int c = 0; c < 60; c++) begin
         if (c == 25) trig = 1'b0;
         if (tdc_start) begin
            nstart++;
            if (nstart == 5) ts5 = c;
         end
         if (valid) begin
            nvalid++;
            if (tv1 < 0) tv1 = c; else if (tv2 < 0) tv2 = c;
         end
         @(negedge clk);
      end
      ready = 1'b0;
      n_checks++; if (tv1 !== 20) begin $display("FAIL b2b_valid1: got %0d expected 20", tv1); n_fail++; end
      n_checks++; if (ts5 !== 22) begin $display("FAIL b2b_restart: got %0d expected 22", ts5); n_fail++; end
      n_checks++; if (tv2 !== 42) begin $display("FAIL b2b_valid2: got %0d expected 42", tv2); n_fail++; end
      n_checks++; if (nstart !== 8) begin $display("FAIL b2b_starts: got %0d expected 8", nstart); n_fail++; end
      n_checks++; if (nvalid !== 2) begin $display("FAIL b2b_valid_cycles: got %0d expected 2", nvalid); n_fail++; end
      n_checks++; if (res !== 32'd8) begin $display("FAIL b2b_mean: got %0d expected 8", res); n_fail++; end
      n_checks++; if ({rmin, rmax} !== {32'd8, 32'd9}) begin $display("FAIL b2b_minmax: got %0d/%0d expected 8/9", rmin, rmax); n_fail++; end
   endtask

   task automatic test_log2_zero;
      int tv;
      logic [31:0] exp_v;
      ready0 = 1'b1;
      for (int b = 0; b < 2; b++) begin
         exp_v    = (b == 0) ? 32'd7 : 32'd9;
         samp0[0] = exp_v;
         sidx0    = 0;
         @(negedge clk) trig0 = 1'b1; window0 = 16'd2;
         @(negedge clk) trig0 = 1'b0;
         tv = -1;
         for (int c = 0; c < 50; c++) begin
            if (valid0) begin tv = c; break; end
            @(negedge clk);
         end
         n_checks++; if (tv !== 6) begin $display("FAIL l0_valid_time: got %0d expected 6", tv); n_fail++; end
         n_checks++; if (res0 !== exp_v) begin $display("FAIL l0_mean: got %0d expected %0d", res0, exp_v); n_fail++; end
         n_checks++;
         if ({rmin0, rmax0} !== {exp_v, exp_v}) begin
            $display("FAIL l0_minmax: got %0d/%0d expected %0d/%0d", rmin0, rmax0, exp_v, exp_v); n_fail++;
         end
         repeat (2) @(negedge clk);
      end
      ready0 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      trig = 1'b0;  window = '0;  ready = 1'b0;  tc = '0;  sidx = 0;
      trig0 = 1'b0; window0 = '0; ready0 = 1'b0; tc0 = '0; sidx0 = 0;
      foreach (samp[i]) samp[i] = '0;
      foreach (samp0[i]) samp0[i] = '0;

      test_reset;
      test_basic;
      test_window_zero;
      test_overflow;
      test_hold;
      test_reset_mid;
      test_back_to_back;
      test_log2_zero;

      n_checks++;
      if (excl_viol !== 0) begin
         $display("FAIL pin_exclusive: %0d overlap cycles expected 0", excl_viol); n_fail++;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer that sits directly upstream and downstream of the ring-oscillator TDC stage. It drives the TDC `start`/`stop` pins with a programmable gate window and captures each `time_count` result. It runs a burst of 2^LOG2_AVG measurements, accumulates them, and presents the mean, minimum and maximum through a valid/ready handshake to the readout logic.

## Interface
- CNT_W, 32: width of TDC `time_count` and of the result outputs.
- WIN_W, 16: width of the `window` input, in clk cycles.
- LOG2_AVG, 3: log2 of the number of samples per burst (N = 2^LOG2_AVG); legal range 0..8.

- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset: asynchronous, active-high; clock clk.
- trig  in  1  request a measurement burst.
- window  in  WIN_W  gate length in cycles; sampled when trig is accepted; 0 is treated as 1.
- time_count  in  CNT_W  result from the TDC stage.
- tdc_start  out  1  to TDC `start`.
- tdc_stop  out  1  to TDC `stop`.
- busy  out  1  high from trig acceptance until the result is transferred.
- result  out  CNT_W  mean of the burst, `acc >> LOG2_AVG` (truncating).
- result_min  out  CNT_W  smallest sample of the burst.
- result_max  out  CNT_W  largest sample of the burst.
- overflow  out  1  sticky for the burst: at least one sample equalled all-ones.
- result_valid  out  1  result, min, max and overflow are stable while high.
- result_ready  in  1  consumer accepts the result.

## Operation
- States: IDLE, START, RUN, STOP, CAPT, DONE.
- IDLE:
  - if trig=1 and result_valid=0, latch W = max(window,1), clear acc/idx/overflow, set min to all-ones and max to 0, then go to START.
  - trig is ignored in every other state.
- START (1 cycle): tdc_start=1, then RUN.
- RUN (W cycles): both TDC pins low; a down-counter of WIN_W bits is loaded with W-1; at 0, go to STOP.
- STOP (2 cycles): tdc_stop=1.
  - The first cycle makes the TDC clear its counting flag.
  - The second cycle (counting=0, stop=1) makes it load time_count.
- CAPT (1 cycle): sample time_count, then:
  - acc += sample; acc is CNT_W+LOG2_AVG bits, so no wrap is possible.
  - min = min(min, sample); max = max(max, sample).
  - overflow |= (sample == all-ones).
  - If idx == N-1, go to DONE; otherwise increment idx and go to START.
- DONE:
  - result_valid=1; outputs are held.
  - On result_valid & result_ready, go to IDLE next cycle with result_valid=0. Outputs keep their values until the next burst's CAPT writes them.
- tdc_start and tdc_stop are never high in the same cycle; both are registered outputs.
- Reset values:
  - State IDLE.
  - result, result_min, result_max, acc, idx and the window counter are 0.
  - overflow, busy, result_valid, tdc_start and tdc_stop are 0.
- Reset asserted mid-burst aborts immediately: both TDC pins drop asynchronously and no partial result is ever presented.
- busy = (state != IDLE).

## Timing
- trig sampled at edge k → tdc_start high in cycle k+1 (t0).
- Sample j:
  - START at t0+j(W+4).
  - STOP at t0+j(W+4)+W+1 and +W+2.
  - CAPT at t0+j(W+4)+W+3.
- result_valid rises at t0+N(W+4) and stays high until the handshake.
- Back-to-back bursts: if result_ready is held high, trig is accepted no earlier than 1 cycle after the transfer cycle.
- Gap from last STOP to next START within a burst is exactly 1 cycle (CAPT). This gives the TDC its required `start && !counting` condition.

## Test plan
- LOG2_AVG=2, window=10, TDC model returns 100, 102, 104, 106 → result=103, min=100, max=106, overflow=0, result_valid rises exactly 56 cycles after the first tdc_start.
- window=0 → behaves as window=1: one RUN cycle, each sample period 5 cycles, tdc_start→tdc_stop spacing 2 cycles.
- A sample of 0xFFFFFFFF within the burst → overflow=1, max=0xFFFFFFFF. With N=4 and samples FFFFFFFF, 1, 1, 1: result=0x40000000 (the accumulator does not wrap).
- result_ready held low for 20 cycles after valid, with trig pulsed meanwhile → outputs stable, trig ignored, no tdc_start; transfer then IDLE.
- rst_n pulsed high during the RUN of sample 2 → tdc_start/tdc_stop/busy/result_valid drop at once. A new trig afterward produces a clean full burst with min/max from fresh data only.
- LOG2_AVG=0, samples 7 then 9 in consecutive bursts → results 7 then 9; min=max=result each time.
